// File: rtl/wave_dump_reader.sv
// Streams one frozen half of the dual-half sample RAM out over a valid/ready byte port.
// A 2-entry FIFO absorbs the 1-cycle RAM read latency and downstream backpressure.
module wave_dump_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             read_index,
  output logic [DEPTH-1:0] read_address,
  input  logic [WIDTH-1:0] read_value,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  // state | meaning
  // IDLE  | waiting for start, read_address holds its last value
  // RUN   | issuing reads for the frozen half and streaming beats
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             half_q;
  logic [DEPTH-1:0] issue_cnt;
  logic [DEPTH-2:0] sent_cnt;
  logic             in_flight;
  logic [WIDTH-1:0] buf_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       occ;
  logic             done_q;
  logic             pop, issue, last_accept, start_dump;
  logic [2:0]       credit;

  assign out_valid    = (occ != 2'd0);
  assign out_data     = buf_mem[rd_ptr];
  assign out_last     = out_valid && (sent_cnt == '1);
  assign busy         = (state == RUN);
  assign done         = done_q;
  assign read_address = {half_q, issue_cnt[DEPTH-2:0]};

  // A beat leaving this cycle frees a slot, which keeps the stream at one beat per cycle.
  assign pop         = out_valid && out_ready;
  assign credit      = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign issue       = (state == RUN) && !issue_cnt[DEPTH-1] && (credit < 3'd2);
  assign last_accept = pop && out_last;
  assign start_dump  = (state == IDLE) && start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      half_q     <= 1'b0;
      issue_cnt  <= '0;
      sent_cnt   <= '0;
      in_flight  <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= last_accept;
      in_flight <= issue;
      if (start_dump) begin
        half_q    <= read_index;
        issue_cnt <= '0;
        sent_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + DEPTH'(1);
        if (pop)   sent_cnt  <= sent_cnt + 1'b1;
      end
      // RAM data for last cycle's read is valid now
      if (in_flight) begin
        buf_mem[wr_ptr] <= read_value;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, in_flight} - {1'b0, pop};
    end
  end

endmodule
